// File: rtl/wb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter_if
//   Bundles every handshake and bus signal of the regfile write-port
//   arbiter. It covers the pipeline writeback request, the long-latency
//   result handshake, the registered regfile write, and the status outputs.
//   Clock and reset are not part of the bundle.
//
//   Modports
//     master : the environment side. It drives the writeback and
//              long-latency requests and observes the regfile write
//              and status.
//     slave  : the arbiter side.
//
//   Signals
//     wb_wd     [4:0]   pipeline writeback destination register
//     wb_wreg           pipeline writeback enable
//     wb_wdata  [31:0]  pipeline writeback data
//     lu_valid          long-latency result valid
//     lu_ready          arbiter can accept a long-latency result
//     lu_wd     [4:0]   long-latency destination register
//     lu_wdata  [31:0]  long-latency result data
//     rf_we             regfile write enable
//     rf_waddr  [4:0]   regfile write address
//     rf_wdata  [31:0]  regfile write data
//     stall_req         bubble request so queued results can drain
//     buf_empty         result queue holds no entries
// ---------------------------------------------------------------------------
interface wb_port_arbiter_if;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_wd;
    logic [31:0] lu_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_req;
    logic        buf_empty;

    modport master (
        output wb_wd, wb_wreg, wb_wdata,
        output lu_valid, lu_wd, lu_wdata,
        input  lu_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req, buf_empty
    );

    modport slave (
        input  wb_wd, wb_wreg, wb_wdata,
        input  lu_valid, lu_wd, lu_wdata,
        output lu_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req, buf_empty
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single regfile write port between two sources. The first is
//   the in-order pipeline writeback. The second is a long-latency result
//   unit that completes out of band. Pipeline writes always win. A
//   long-latency result is queued in a small FIFO and is written in a cycle
//   with no pipeline write. A starvation counter raises stall_req when the
//   queue has waited too long, so the pipeline controller can insert a
//   bubble.
//
//   Parameters
//     DEPTH       FIFO entries (power of 2, >= 2)
//     STARVE_MAX  number of consecutive non-empty cycles without a pop
//                 before stall_req asserts (>= 1)
//
//   Ports
//     clk   clock; all state changes on the rising edge
//     rst   synchronous reset, active low
//     bus   wb_port_arbiter_if.slave; carries all request, write and
//           status signals
//
//   Optional feature (compile-time macro WBARB_WAW_KILL_EN)
//     When the macro is defined, a winning pipeline write to register A
//     marks every queued entry whose destination is A as dead. A dead entry
//     still takes a pop cycle, but it produces rf_we=0. This stops an older
//     long-latency value from overwriting a newer pipeline value.
//     When the macro is not defined, every queued entry is written.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    // Queue storage. The head is read combinationally because the pop
    // decision and the registered write both happen in the same cycle.
    logic [4:0]    wd_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic          popped_q;

    logic          rf_we_q;
    logic [4:0]    rf_waddr_q;
    logic [31:0]   rf_wdata_q;

    logic          prim;
    logic          not_empty;
    logic          ready;
    logic          pop;
    logic          push;
    logic          head_live;

    // A pipeline write to $0 is not a request, so the FIFO may use that slot.
    assign prim      = bus.wb_wreg && (bus.wb_wd != 5'd0);
    assign not_empty = (count_q != '0);
    assign ready     = (count_q < CW'(DEPTH));
    assign pop       = !prim && not_empty;
    // A result for $0 completes the handshake but is never stored.
    assign push      = bus.lu_valid && ready && (bus.lu_wd != 5'd0);

`ifdef WBARB_WAW_KILL_EN
    logic [DEPTH-1:0] dead_q;
    logic [DEPTH-1:0] dead_d;

    // A slot written this cycle always starts live. The new result is
    // treated as newer than the pipeline write in the same cycle. Other
    // slots that match the winning pipeline address are killed. A stale
    // match in an unused slot does no harm, because a later push clears it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dead
        assign dead_d[gi] = (push && (tail_q == AW'(gi))) ? 1'b0 :
                            (prim && (wd_mem[gi] == bus.wb_wd)) ? 1'b1 :
                            dead_q[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end

    assign head_live = !dead_q[head_q];
`else
    assign head_live = 1'b1;
`endif

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end
        if (push) begin
            tail_d = tail_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // The starvation counter runs while entries wait without being drained.
    // When the counter reaches its limit, stall_req is set. stall_req is
    // released only in the cycle after a pop, so the controller sees it for
    // one extra cycle while the pipeline bubble takes effect.
    always_comb begin
        starve_d = starve_q;
        if (pop || !not_empty) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        stall_d = stall_q;
        if (popped_q) begin
            stall_d = 1'b0;
        end else if (starve_d == SW'(STARVE_MAX)) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            wd_mem[tail_q]   <= bus.lu_wd;
            data_mem[tail_q] <= bus.lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            stall_q    <= 1'b0;
            popped_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            popped_q <= pop;
            if (prim) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= bus.wb_wd;
                rf_wdata_q <= bus.wb_wdata;
            end else if (pop) begin
                // A dead head uses this slot but writes nothing.
                rf_we_q <= head_live;
                if (head_live) begin
                    rf_waddr_q <= wd_mem[head_q];
                    rf_wdata_q <= data_mem[head_q];
                end
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign bus.lu_ready  = ready;
    assign bus.buf_empty = !not_empty;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.stall_req = stall_q;

endmodule
